// File: rtl/inv_key_schedule128.sv
// AES-128 decryption key scheduler: expands the cipher key forward to
// round key 10, then streams round keys 10..0 using the inverse recurrence.
module inv_key_schedule128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    EMIT
  } state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [10:0] hi;
    hi = 11'd2047 - {b, 3'b000};
    return SBOX[hi -: 8];
  endfunction

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   cnt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] rcon;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic        fire;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  always_comb begin
    rcon = 32'h0;
    unique case (cnt)
      4'd1:    rcon = 32'h01000000;
      4'd2:    rcon = 32'h02000000;
      4'd3:    rcon = 32'h04000000;
      4'd4:    rcon = 32'h08000000;
      4'd5:    rcon = 32'h10000000;
      4'd6:    rcon = 32'h20000000;
      4'd7:    rcon = 32'h40000000;
      4'd8:    rcon = 32'h80000000;
      4'd9:    rcon = 32'h1b000000;
      4'd10:   rcon = 32'h36000000;
      default: rcon = 32'h0;
    endcase
  end

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // One SubWord shared by both directions; RotWord applied before the mux
  assign sub_in = (state == EXPAND) ? {w3[23:0], w3[31:24]}
                                    : {p3[23:0], p3[31:24]};

  assign sub_out = {sb(sub_in[31:24]), sb(sub_in[23:16]),
                    sb(sub_in[15:8]),  sb(sub_in[7:0])};

  assign n0 = w0 ^ sub_out ^ rcon;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;
  assign p0 = w0 ^ sub_out ^ rcon;

  assign fire = (state == EMIT) && rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      key_reg  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // a start coinciding with the done pulse is dropped
          if (start && !done) begin
            key_reg <= key_in;
            cnt     <= 4'd1;
            busy    <= 1'b1;
            state   <= EXPAND;
          end
        end
        EXPAND: begin
          key_reg <= {n0, n1, n2, n3};
          if (cnt == 4'd10) begin
            rk_valid <= 1'b1;
            state    <= EMIT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        EMIT: begin
          if (fire) begin
            if (cnt == 4'd0) begin
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              key_reg <= {p0, p1, p2, p3};
              cnt     <= cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rk_out = key_reg;
  assign rk_idx = cnt;

endmodule

// File: tb/tb_inv_key_schedule128.sv
// Bench for inv_key_schedule128: FIPS vectors, stalls, start/rst abuse and
// random keys against a GF(2^8)-derived key expansion model.
module tb_inv_key_schedule128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  inv_key_schedule128 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sm     [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  localparam logic [127:0] KA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xt(a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sm[b] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
            ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sm[x[31:24]], sm[x[23:16]], sm[x[15:8]], sm[x[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [127:0] k, input bit rnd_ready,
                     input bit hammer);
    int cyc, e, stalls, first_v;
    bit stalled, seen_done;
    logic [127:0] po;
    logic [3:0] pi;
    expand(k);
    key_in = k;
    start = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; e = 10; stalls = 0; first_v = -1;
    stalled = 0; seen_done = 0; po = '0; pi = '0;
    while (cyc < 200) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      chk("busy", busy, 1);
      if (rk_valid) begin
        if (e < 0) begin
          chk("extra_key", rk_valid, 0);
          break;
        end
        if (first_v < 0) first_v = cyc;
        if (stalled) begin
          chk("hold_out", rk_out, po);
          chk("hold_idx", rk_idx, pi);
        end
        chk("idx", rk_idx, e);
        chk("key", rk_out, exp_rk[e]);
        got_rk[e] = rk_out;
        rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !rk_ready;
        po = rk_out;
        pi = rk_idx;
        if (rk_ready) e--;
        else stalls++;
      end else begin
        rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = 0;
      end
      if (hammer) start = 1'($urandom_range(0, 1));
      cyc++;
      step();
    end
    chk("done_seen", seen_done, 1);
    chk("done_cyc", cyc, 22 + stalls);
    chk("first_valid", first_v, 11);
    chk("keys_left", e + 1, 0);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", rk_valid, 0);
    start = hammer;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    chk("done_width", done, 0);
    chk("start_in_done", busy, 0);
  endtask

  task automatic run_abort(input logic [127:0] k, input bit in_emit);
    int cyc;
    key_in = k;
    start = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (!in_emit && cyc == 5) break;
      if (in_emit && rk_valid && rk_idx == 4'd4) break;
      cyc++;
      step();
    end
    chk("abort_point", cyc < 100, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", rk_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_out", rk_out, 0);
    chk("abort_idx", rk_idx, 0);
    repeat (3) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    rk_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", rk_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out", rk_out, 0);
    chk("rst_idx", rk_idx, 0);
    rst = 1'b0;

    run(KA1, 0, 0);
    chk("a1_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a1_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_rk0", got_rk[0], KA1);

    run(KA1, 1, 0);
    run(KA1, 0, 1);
    run(KA1, 1, 1);
    run(KA1, 0, 0);

    run_abort(KA1, 0);
    run(KA1, 0, 0);
    run_abort(KA1, 1);
    run(KA1, 0, 0);
    chk("post_rst_rk0", got_rk[0], KA1);

    run(128'h0, 0, 0);
    chk("zero_rk10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_rk0", got_rk[0], 128'h0);

    for (int i = 0; i < 1000; i++)
      run({$urandom, $urandom, $urandom, $urandom}, i[0], (i % 3) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
